// File: rtl/word_unpack_pkg.sv
// rtl/word_unpack_pkg.sv - shared widths and types for the word unpacker
package word_unpack_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [1:0]        byte_idx_t;

  // Index of the final byte of a word; idx wraps to 0 after this one.
  localparam byte_idx_t LAST_IDX = byte_idx_t'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - word FIFO with occupancy level, unreset storage
module word_fifo
  import word_unpack_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic                       push,
  input  word_t                      wdata,
  input  logic                       pop,
  output word_t                      rdata,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  word_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage is written on push only; contents are don't-care until level says otherwise.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; level tracks net push/pop.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/word_unpacker.sv
// rtl/word_unpacker.sv - word-to-byte unpacker; WORD_UNPACKER_LSB_FIRST_EN selects byte 0 first
module word_unpacker
  import word_unpack_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic [WORD_W-1:0]          wordIn,
  input  logic                       wordValid,
  output logic                       wordReady,
  output logic [BYTE_W-1:0]          byteOut,
  output logic                       byteValid,
  input  logic                       byteReady,
  output logic                       lastByte,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  word_t     head;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  logic      byte_fire;
  byte_idx_t idx;
  byte_idx_t lane;

  // wordReady comes from registered level only, so byteReady never reaches it combinationally.
  assign wordReady = !full;
  assign byteValid = !empty;
  assign push      = wordValid && wordReady;
  assign byte_fire = byteValid && byteReady;
  assign pop       = byte_fire && (idx == LAST_IDX);
  assign lastByte  = byteValid && (idx == LAST_IDX);

  word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .clear (clear),
    .push  (push),
    .wdata (wordIn),
    .pop   (pop),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Byte index advances on each accepted byte and wraps to 0 with the word pop.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      idx <= '0;
    end else if (byte_fire) begin
      idx <= idx + 1'b1;
    end
  end

  // Map emission order onto a byte lane of the head word; output is zero when idle.
  always_comb begin
    lane = '0;
`ifdef WORD_UNPACKER_LSB_FIRST_EN
    lane = idx;
`else
    lane = LAST_IDX - idx;
`endif
    byteOut = '0;
    if (byteValid) begin
      byteOut = head[{lane, 3'b000} +: BYTE_W];
    end
  end

endmodule

// File: tb/tb_word_unpacker.sv
// tb/tb_word_unpacker.sv - directed self-checking bench for word_unpacker
module tb_word_unpacker;

  logic        clock;
  logic        clear;
  logic [31:0] wordIn;
  logic        wordValid;
  logic        wordReady;
  logic [7:0]  byteOut;
  logic        byteValid;
  logic        byteReady;
  logic        lastByte;
  logic [1:0]  level;

  int checks;
  int errors;

  word_unpacker #(.DEPTH(2)) dut (
    .clock     (clock),
    .clear     (clear),
    .wordIn    (wordIn),
    .wordValid (wordValid),
    .wordReady (wordReady),
    .byteOut   (byteOut),
    .byteValid (byteValid),
    .byteReady (byteReady),
    .lastByte  (lastByte),
    .level     (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected n-th emitted byte (n = 0..3) of a word in the configured order.
  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int n);
    logic [31:0] s;
`ifdef WORD_UNPACKER_LSB_FIRST_EN
    s = w >> (8 * n);
`else
    s = w >> (8 * (3 - n));
`endif
    return s[7:0];
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    clear = 1'b1; wordValid = 1'b0; wordIn = '0; byteReady = 1'b0;
    step; step;
    checks++; if (wordReady !== 1'b1) begin errors++; $display("FAIL reset_wordReady got %b exp 1", wordReady); end
    checks++; if (byteValid !== 1'b0) begin errors++; $display("FAIL reset_byteValid got %b exp 0", byteValid); end
    checks++; if (byteOut !== 8'h00) begin errors++; $display("FAIL reset_byteOut got %h exp 00", byteOut); end
    checks++; if (lastByte !== 1'b0) begin errors++; $display("FAIL reset_lastByte got %b exp 0", lastByte); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    clear = 1'b0;
    step;
  endtask

  task automatic test_single;
    logic [31:0] w;
    w = 32'hA1B2C3D4;
    wordIn = w; wordValid = 1'b1; byteReady = 1'b1;
    step;
    wordValid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      checks++; if (byteValid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d] got %b exp 1", n, byteValid); end
      checks++; if (byteOut !== exp_byte(w, n)) begin errors++; $display("FAIL single_byte[%0d] got %h exp %h", n, byteOut, exp_byte(w, n)); end
      checks++; if (lastByte !== (n == 3)) begin errors++; $display("FAIL single_last[%0d] got %b exp %b", n, lastByte, (n == 3)); end
      step;
    end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL single_level_after got %0d exp 0", level); end
    checks++; if (byteValid !== 1'b0) begin errors++; $display("FAIL single_idle_valid got %b exp 0", byteValid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w [2];
    w[0] = 32'h11223344; w[1] = 32'h55667788;
    byteReady = 1'b0;
    wordIn = w[0]; wordValid = 1'b1; step;
    wordIn = w[1]; step;
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL b2b_level_full got %0d exp 2", level); end
    checks++; if (wordReady !== 1'b0) begin errors++; $display("FAIL b2b_wordReady_full got %b exp 0", wordReady); end
    wordIn = 32'h99AABBCC; step;
    wordValid = 1'b0;
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL b2b_third_rejected got %0d exp 2", level); end
    byteReady = 1'b1;
    for (int n = 0; n < 8; n++) begin
      checks++; if (byteOut !== exp_byte(w[n / 4], n % 4)) begin errors++; $display("FAIL b2b_byte[%0d] got %h exp %h", n, byteOut, exp_byte(w[n / 4], n % 4)); end
      step;
    end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL b2b_level_drained got %0d exp 0", level); end
  endtask

  task automatic test_backpressure;
    logic [31:0] w;
    int k;
    w = 32'hDEADBEEF;
    byteReady = 1'b0;
    wordIn = w; wordValid = 1'b1; step;
    wordValid = 1'b0;
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      byteReady = c[0];
      checks++; if (byteOut !== exp_byte(w, k)) begin errors++; $display("FAIL bp_byte[c%0d] got %h exp %h", c, byteOut, exp_byte(w, k)); end
      if (byteReady) k++;
      step;
    end
    checks++; if (k !== 4) begin errors++; $display("FAIL bp_timeout got %0d bytes exp 4", k); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL bp_level got %0d exp 0", level); end
    byteReady = 1'b1;
  endtask

  task automatic test_simultaneous;
    logic [31:0] w [4];
    int  n;
    int  pushed;
    logic do_push;
    w[0] = 32'h0A0B0C0D; w[1] = 32'h1A1B1C1D; w[2] = 32'h2A2B2C2D; w[3] = 32'h3A3B3C3D;
    byteReady = 1'b1;
    wordIn = w[0]; wordValid = 1'b1; step;
    wordValid = 1'b0;
    pushed = 1; n = 0;
    for (int c = 0; c < 40 && n < 16; c++) begin
      checks++;
      if (byteValid !== 1'b1) begin
        errors++; $display("FAIL sim_bubble[c%0d] got %b exp 1", c, byteValid);
      end else begin
        checks++; if (byteOut !== exp_byte(w[n / 4], n % 4)) begin errors++; $display("FAIL sim_byte[%0d] got %h exp %h", n, byteOut, exp_byte(w[n / 4], n % 4)); end
        n++;
      end
      do_push = lastByte && (pushed < 4);
      if (do_push) begin
        wordIn = w[pushed]; wordValid = 1'b1; pushed++;
      end
      step;
      wordValid = 1'b0;
      if (do_push) begin
        checks++; if (level !== 2'd1) begin errors++; $display("FAIL sim_level_hold got %0d exp 1", level); end
      end
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL sim_timeout got %0d bytes exp 16", n); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL sim_level_end got %0d exp 0", level); end
  endtask

  task automatic test_clear_mid;
    logic [31:0] w;
    w = 32'hCAFEF00D;
    byteReady = 1'b1;
    wordIn = w; wordValid = 1'b1; step;
    wordValid = 1'b0;
    step;
    checks++; if (byteOut !== exp_byte(w, 1)) begin errors++; $display("FAIL clr_second_byte got %h exp %h", byteOut, exp_byte(w, 1)); end
    #1 clear = 1'b1;
    #1;
    checks++; if (byteValid !== 1'b0) begin errors++; $display("FAIL clr_async_valid got %b exp 0", byteValid); end
    checks++; if (byteOut !== 8'h00) begin errors++; $display("FAIL clr_async_byteOut got %h exp 00", byteOut); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL clr_async_level got %0d exp 0", level); end
    checks++; if (wordReady !== 1'b1) begin errors++; $display("FAIL clr_async_wordReady got %b exp 1", wordReady); end
    checks++; if (lastByte !== 1'b0) begin errors++; $display("FAIL clr_async_lastByte got %b exp 0", lastByte); end
    step;
    clear = 1'b0;
    step;
    w = 32'h01020304;
    wordIn = w; wordValid = 1'b1; step;
    wordValid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      checks++; if (byteOut !== exp_byte(w, n)) begin errors++; $display("FAIL clr_restart_byte[%0d] got %h exp %h", n, byteOut, exp_byte(w, n)); end
      checks++; if (lastByte !== (n == 3)) begin errors++; $display("FAIL clr_restart_last[%0d] got %b exp %b", n, lastByte, (n == 3)); end
      step;
    end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL clr_restart_level got %0d exp 0", level); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_simultaneous;
    test_clear_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_unpacker.md
# word_unpacker

Downstream stage of the byte-packing `Device`. Accepts assembled 32-bit words on a valid/ready handshake, buffers them in a small FIFO, and emits them as a serial byte stream on a second valid/ready handshake. The default byte order is MSB-first, so bytes come out in the order they were originally shifted in.

## Interface
Parameters:
- `DEPTH`, default 2: word FIFO depth in entries; power of two, ≥ 2.

Ports:
- `clock`  input  1: sole clock; all state changes on the rising edge.
- `clear`  input  1: asynchronous, active-high reset.
- `wordIn`  input  32: word to unpack.
- `wordValid`  input  1: `wordIn` is valid.
- `wordReady`  output  1: the block can accept a word this cycle.
- `byteOut`  output  8: current output byte.
- `byteValid`  output  1: `byteOut` is valid.
- `byteReady`  input  1: the downstream side accepts `byteOut`.
- `lastByte`  output  1: `byteOut` is the final byte of its word.
- `level`  output  $clog2(DEPTH+1): number of words held, including the word currently being drained.

## Operation
- Push: a word is accepted when `wordValid && wordReady`. It is written at the write pointer, the write pointer increments (wraps at `DEPTH`), and `level` increments.
- `wordReady = (level != DEPTH)`. It depends only on registered state; there is no combinational path from `byteReady`.
- Output presents the head word, byte index `idx` (2 bits, 0..3).
  - `byteValid = (level != 0)`.
  - `byteOut = head[31-8*idx -: 8]`.
  - `byteOut` is forced to 8'h00 when `!byteValid`.
- Pop: on `byteValid && byteReady`:
  - If `idx != 3`, `idx` increments.
  - If `idx == 3`, `idx` returns to 0, the read pointer increments (wraps), and `level` decrements.
- `lastByte = byteValid && (idx == 3)`.
- Derived states:
  - EMPTY (`level == 0`): `byteValid=0`, `wordReady=1`.
  - PARTIAL (`0 < level < DEPTH`): both high.
  - FULL (`level == DEPTH`): `wordReady=0`.
- Push and final-byte pop in the same cycle: `level` is unchanged and both pointers advance.
  - In FULL, no push occurs that cycle because `wordReady` was 0. `wordReady` rises the following cycle.
- `byteValid` low with `byteReady` high: no effect.
- Holding rule: while `byteValid && !byteReady`, `byteOut`, `lastByte` and `idx` stay stable.

## Timing
- Reset (asserted asynchronously, released synchronously to `clock`):
  - `level=0`, pointers 0, `idx=0`.
  - Outputs: `wordReady=1`, `byteValid=0`, `byteOut=8'h00`, `lastByte=0`, `level=0`.
- FIFO storage is not reset.
- Reset mid-word: the partially emitted word and all queued words are discarded. There is no resumption after release.
- Latency: a word accepted at edge N gives its first byte valid after edge N (cycle N+1).
- Throughput: one byte per cycle with `byteReady` held high. One word per 4 cycles is sustained without bubbles for `DEPTH ≥ 2`.

## Configuration
- `WORD_UNPACKER_LSB_FIRST_EN`:
  - Defined: `byteOut = head[8*idx +: 8]` (byte 0 first). `lastByte` still marks `idx == 3`.
  - Undefined (default): MSB-first, as described in Operation.

## Structure
- Package `word_unpack_pkg` holds:
  - Constants `WORD_W=32`, `BYTE_W=8`, `BYTES_PER_WORD=4`.
  - Typedefs `word_t`, `byte_t`, `byte_idx_t` (2-bit).
- Sub-module `word_fifo`: parameterized storage, pointers and `level`, with push/pop/full/empty.
- `word_unpacker` holds `idx`, the byte select, the handshakes and the macro-controlled ordering.

## Test plan
- Reset, then push 32'hA1B2C3D4 with `byteReady=1`:
  - `byteOut` sequence A1, B2, C3, D4 on cycles N+1..N+4.
  - `lastByte` high only with D4; `level` returns to 0 after D4.
- Push 32'h11223344 and 32'h55667788 back-to-back, with `byteReady=0`:
  - `level=2` and `wordReady=0`.
  - A third word offered is not accepted.
  - Releasing `byteReady` drains 11..44 then 55..88.
- Backpressure: toggle `byteReady` every cycle during 32'hDEADBEEF:
  - `byteOut` stays stable while stalled.
  - DE, AD, BE, EF each appear exactly once.
- Simultaneous push and final-byte pop at `level=1`:
  - `level` stays 1 and the next word starts the following cycle with no bubble.
  - Pointers wrap correctly over 2·`DEPTH` words.
- Assert `clear` while emitting the second byte of 32'hCAFEF00D:
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - After release, push 32'h01020304 → 01, 02, 03, 04.
- With `WORD_UNPACKER_LSB_FIRST_EN` defined, push 32'hA1B2C3D4 → D4, C3, B2, A1, with `lastByte` on A1.
